// File: rtl/tim_apb_arbiter.sv
// -----------------------------------------------------------------------------
// tim_apb_arbiter
// Two-requester APB master front-end for the timer register slave. Requester 0
// (CPU bridge) and requester 1 (debug/DMA) share one APB port under round-robin
// arbitration. The block runs the APB setup/access phases, waits on tim_pready
// and gives up with an error once TIMEOUT_CYC access cycles pass without it.
//
// Ports
//   sys_clk, sys_rst_n          clock (rising edge), async active-low reset
//   mN_req/write/addr/wdata     requester N transfer (held until mN_ack)
//   mN_ack/err/rdata            one-cycle completion, timeout flag, read data
//   tim_psel/penable/pwrite     APB control to the timer slave
//   tim_paddr/pwdata            APB address / write data
//   tim_prdata/pready           APB read data / ready from the timer slave
//   busy                        high whenever the FSM is not in IDLE
//
// Every output is a flop loaded from next-state logic, so no input reaches an
// output combinationally.
// -----------------------------------------------------------------------------
module tim_apb_arbiter #(
   parameter int AW          = 12,
   parameter int DW          = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   input  logic          m0_req,
   input  logic          m0_write,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_ack,
   output logic          m0_err,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_write,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_ack,
   output logic          m1_err,
   output logic [DW-1:0] m1_rdata,
   output logic          tim_psel,
   output logic          tim_penable,
   output logic          tim_pwrite,
   output logic [AW-1:0] tim_paddr,
   output logic [DW-1:0] tim_pwdata,
   input  logic [DW-1:0] tim_prdata,
   input  logic          tim_pready,
   output logic          busy
);

   // state    | meaning
   // ---------+-----------------------------------------------------------
   // S_IDLE   | no transfer; arbitrate pending requests
   // S_SETUP  | APB setup phase (psel=1, penable=0)
   // S_ACCESS | APB access phase, waiting on tim_pready or timeout
   // S_DONE   | APB released; winner's ack/err pulse is visible
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

   state_t     state;
   state_t     next_state;
   logic [7:0] acc_cnt;
   logic       grant;
   logic       last_grant;
   logic       win_valid;
   logic       win_id;
   logic       xfer_ok;
   logic       timeout_hit;
   logic       xfer_end;
   logic       rd_capture;

   always_comb begin
      next_state  = state;
      win_valid   = 1'b0;
      win_id      = 1'b0;
      xfer_ok     = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         S_IDLE: begin
            if (m0_req || m1_req) begin
               win_valid  = 1'b1;
               // On a tie the requester that was not served last goes first.
               win_id     = (m0_req && m1_req) ? ~last_grant : m1_req;
               next_state = S_SETUP;
            end
         end
         S_SETUP: next_state = S_ACCESS;
         S_ACCESS: begin
            // pready on the final allowed cycle still counts as success.
            if (tim_pready) begin
               xfer_ok    = 1'b1;
               next_state = S_DONE;
            end else if (acc_cnt == CNT_LAST) begin
               timeout_hit = 1'b1;
               next_state  = S_DONE;
            end
         end
         S_DONE: next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   assign xfer_end   = xfer_ok | timeout_hit;
   assign rd_capture = xfer_ok & ~tim_pwrite;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state       <= S_IDLE;
         acc_cnt     <= 8'd0;
         grant       <= 1'b0;
         last_grant  <= 1'b1;
         busy        <= 1'b0;
         tim_psel    <= 1'b0;
         tim_penable <= 1'b0;
         tim_pwrite  <= 1'b0;
         tim_paddr   <= '0;
         tim_pwdata  <= '0;
         m0_ack      <= 1'b0;
         m0_err      <= 1'b0;
         m0_rdata    <= '0;
         m1_ack      <= 1'b0;
         m1_err      <= 1'b0;
         m1_rdata    <= '0;
      end else begin
         state       <= next_state;
         busy        <= (next_state != S_IDLE);
         tim_psel    <= (next_state == S_SETUP) || (next_state == S_ACCESS);
         tim_penable <= (next_state == S_ACCESS);

         if (win_valid) begin
            grant      <= win_id;
            last_grant <= win_id;
            tim_pwrite <= win_id ? m1_write : m0_write;
            tim_paddr  <= win_id ? m1_addr  : m0_addr;
            tim_pwdata <= win_id ? m1_wdata : m0_wdata;
         end

         if (state == S_ACCESS) begin
            acc_cnt <= acc_cnt + 8'd1;
         end else begin
            acc_cnt <= 8'd0;
         end

         m0_ack <= xfer_end    & ~grant;
         m1_ack <= xfer_end    &  grant;
         m0_err <= timeout_hit & ~grant;
         m1_err <= timeout_hit &  grant;

         if (rd_capture && !grant) begin
            m0_rdata <= tim_prdata;
         end
         if (rd_capture && grant) begin
            m1_rdata <= tim_prdata;
         end
      end
   end

endmodule

// File: tb/tb_tim_apb_arbiter.sv
module tb_tim_apb_arbiter;
   localparam int AW = 12;
   localparam int DW = 32;
   localparam int TO = 16;

   logic          sys_clk = 1'b0;
   logic          sys_rst_n = 1'b0;
   logic          m0_req = 1'b0, m0_write = 1'b0;
   logic [AW-1:0] m0_addr = '0;
   logic [DW-1:0] m0_wdata = '0;
   logic          m0_ack, m0_err;
   logic [DW-1:0] m0_rdata;
   logic          m1_req = 1'b0, m1_write = 1'b0;
   logic [AW-1:0] m1_addr = '0;
   logic [DW-1:0] m1_wdata = '0;
   logic          m1_ack, m1_err;
   logic [DW-1:0] m1_rdata;
   logic          tim_psel, tim_penable, tim_pwrite;
   logic [AW-1:0] tim_paddr;
   logic [DW-1:0] tim_pwdata;
   logic [DW-1:0] tim_prdata = '0;
   logic          tim_pready = 1'b0;
   logic          busy;

   tim_apb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYC(TO)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
      .tim_psel(tim_psel), .tim_penable(tim_penable), .tim_pwrite(tim_pwrite),
      .tim_paddr(tim_paddr), .tim_pwdata(tim_pwdata), .tim_prdata(tim_prdata),
      .tim_pready(tim_pready), .busy(busy)
   );

   always #5 sys_clk = ~sys_clk;

   // One transfer: who issues it, its fields, the data the slave returns and
   // the access cycle (1-based) on which the slave raises pready.
   typedef struct {
      bit            id;
      bit            write;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
      int            k;
   } txn_t;

   txn_t exp_q[$];
   txn_t slv_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   logic [DW-1:0] mdl_rdata [2];
   bit   mdl_last = 1'b1;
   bit   rd_pend = 1'b0;
   bit   mon_en = 1'b0;
   int   setup_cyc = 0;
   int   pen_cnt = 0;

   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   function automatic int keff(input int k);
      return (k > TO) ? TO : k;
   endfunction

   // ---------------- timer slave model ----------------
   txn_t cur;
   int   acc = 0;
   always @(negedge sys_clk) begin
      if (!sys_rst_n) begin
         tim_pready = 1'b0;
         acc = 0;
      end else if (tim_psel && !tim_penable) begin
         if (slv_q.size() == 0) begin
            fail("slave_unexpected_setup");
         end else begin
            cur = slv_q.pop_front();
            acc = 0;
            chk("setup_paddr", tim_paddr, cur.addr);
            chk("setup_pwrite", tim_pwrite, cur.write);
            chk("setup_pwdata", tim_pwdata, cur.wdata);
         end
         tim_pready = 1'($urandom % 2);
         tim_prdata = $urandom;
      end else if (tim_psel && tim_penable) begin
         acc++;
         chk("access_paddr", tim_paddr, cur.addr);
         chk("access_pwrite", tim_pwrite, cur.write);
         chk("access_pwdata", tim_pwdata, cur.wdata);
         tim_pready = (acc == cur.k);
         tim_prdata = (acc == cur.k) ? cur.rdata : $urandom;
      end else begin
         tim_pready = 1'($urandom % 2);
         tim_prdata = $urandom;
      end
   end

   // ---------------- scoreboard monitor ----------------
   always @(negedge sys_clk) begin
      txn_t e;
      if (sys_rst_n && mon_en) begin
         chk("busy_vs_phase", busy, tim_psel | m0_ack | m1_ack);
         chk("err_without_ack", {m0_err & ~m0_ack, m1_err & ~m1_ack}, 2'b00);
         if (tim_penable && !tim_psel) fail("penable_without_psel");
         if (tim_psel && !tim_penable) begin
            setup_cyc = cyc;
            pen_cnt = 0;
         end
         if (tim_penable) pen_cnt++;
         if (rd_pend) begin
            chk("m0_rdata", m0_rdata, mdl_rdata[0]);
            chk("m1_rdata", m1_rdata, mdl_rdata[1]);
            rd_pend = 1'b0;
         end
         if (m0_ack || m1_ack) begin
            if (exp_q.size() == 0) begin
               fail("unexpected_ack");
            end else begin
               e = exp_q.pop_front();
               chk("ack0", m0_ack, e.id == 1'b0);
               chk("ack1", m1_ack, e.id == 1'b1);
               chk("err", e.id ? m1_err : m0_err, e.k > TO);
               chk("psel_in_done", {tim_psel, tim_penable}, 2'b00);
               chk("setup_to_ack_cycles", cyc - setup_cyc, keff(e.k) + 1);
               chk("penable_cycles", pen_cnt, keff(e.k));
               if (!e.write && e.k <= TO) mdl_rdata[e.id] = e.rdata;
               rd_pend = 1'b1;
            end
         end
      end
   end

   function automatic txn_t rnd_txn();
      txn_t t;
      t.id    = 1'b0;
      t.write = 1'($urandom % 2);
      t.addr  = AW'($urandom);
      t.wdata = $urandom;
      t.rdata = $urandom;
      t.k     = ($urandom % 4 == 0) ? int'($urandom_range(TO - 1, TO + 3)) : int'($urandom_range(1, 5));
      return t;
   endfunction

   function automatic txn_t mk(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                               input logic [DW-1:0] rd, input int k);
      txn_t t;
      t.id = 1'b0; t.write = w; t.addr = a; t.wdata = wd; t.rdata = rd; t.k = k;
      return t;
   endfunction

   task automatic push(input txn_t t);
      exp_q.push_back(t);
      slv_q.push_back(t);
   endtask

   // Called at a negedge while the arbiter is idle. Requests stay up until
   // their own ack, then drop in that ack cycle.
   task automatic run_round(input bit r0, input bit r1, input txn_t t0, input txn_t t1);
      int n;
      t0.id = 1'b0;
      t1.id = 1'b1;
      if (r0 && r1) begin
         // Tie goes to the requester not served last; the other follows.
         if (mdl_last) begin push(t0); push(t1); mdl_last = 1'b1; end
         else          begin push(t1); push(t0); mdl_last = 1'b0; end
      end else if (r0) begin
         push(t0); mdl_last = 1'b0;
      end else if (r1) begin
         push(t1); mdl_last = 1'b1;
      end
      if (r0) begin m0_req = 1'b1; m0_write = t0.write; m0_addr = t0.addr; m0_wdata = t0.wdata; end
      if (r1) begin m1_req = 1'b1; m1_write = t1.write; m1_addr = t1.addr; m1_wdata = t1.wdata; end
      n = 0;
      while ((m0_req || m1_req) && n < 200) begin
         @(negedge sys_clk);
         n++;
         if (m0_ack) begin m0_req = 1'b0; m0_addr = AW'($urandom); m0_wdata = $urandom; end
         if (m1_ack) begin m1_req = 1'b0; m1_addr = AW'($urandom); m1_wdata = $urandom; end
      end
      if (m0_req || m1_req) begin
         fail("round_no_ack_within_200_cycles");
         m0_req = 1'b0;
         m1_req = 1'b0;
      end
   endtask

   task automatic gap();
      repeat (1 + $urandom % 3) @(negedge sys_clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      txn_t t0, t1;
      int   ackc[3];
      int   acks, c0, n, mode;
      mdl_rdata[0] = '0;
      mdl_rdata[1] = '0;

      repeat (2) @(negedge sys_clk);
      chk("reset_outputs", {m0_ack, m0_err, m1_ack, m1_err, tim_psel, tim_penable, tim_pwrite, busy}, 8'h00);
      chk("reset_paddr", tim_paddr, 0);
      chk("reset_pwdata", tim_pwdata, 0);
      chk("reset_rdata", {m0_rdata, m1_rdata}, 0);

      // Both requesters from reset release: m0 write first, then m1 read.
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      mon_en = 1'b1;
      run_round(1'b1, 1'b1, mk(1'b1, 12'h004, 32'h0000_00A5, 32'h0, 2),
                           mk(1'b0, 12'h010, 32'h0, 32'hDEAD_BEEF, 2));
      @(negedge sys_clk);
      chk("m1_read_deadbeef", m1_rdata, 32'hDEAD_BEEF);
      chk("m0_rdata_untouched", m0_rdata, 32'h0);

      // Tie again: alternation must hand it to m0 first.
      gap();
      run_round(1'b1, 1'b1, rnd_txn(), rnd_txn());

      // Timeout boundaries: success on the last allowed cycle, then the first
      // failing case, then a slave that never answers a read.
      gap();
      run_round(1'b1, 1'b0, mk(1'b0, 12'h020, 32'h1, 32'h1234_5678, TO), rnd_txn());
      gap();
      run_round(1'b1, 1'b0, mk(1'b0, 12'h024, 32'h2, 32'hAAAA_5555, TO + 1), rnd_txn());
      gap();
      run_round(1'b0, 1'b1, rnd_txn(), mk(1'b0, 12'h028, 32'h3, 32'h5555_AAAA, 1000));

      // m0 held for three back-to-back transfers.
      gap();
      t0 = mk(1'b1, 12'h0FC, 32'hC0FF_EE00, 32'h0, 2);
      push(t0); push(t0); push(t0);
      mdl_last = 1'b0;
      c0 = cyc;
      m0_req = 1'b1; m0_write = t0.write; m0_addr = t0.addr; m0_wdata = t0.wdata;
      acks = 0; n = 0;
      while (acks < 3 && n < 60) begin
         @(negedge sys_clk);
         n++;
         if (m0_ack) begin
            ackc[acks] = cyc - c0;
            acks++;
            if (acks == 3) m0_req = 1'b0;
         end
      end
      if (acks < 3) begin
         fail("b2b_missing_acks");
         m0_req = 1'b0;
      end else begin
         chk("b2b_ack_c4", ackc[0], 4);
         chk("b2b_ack_c9", ackc[1], 9);
         chk("b2b_ack_c14", ackc[2], 14);
      end

      // Reset pulsed during ACCESS, then m0 re-presents its request.
      gap();
      t0 = mk(1'b1, 12'h040, 32'h0BAD_F00D, 32'h0, 1000);
      slv_q.push_back(t0);
      m0_req = 1'b1; m0_write = t0.write; m0_addr = t0.addr; m0_wdata = t0.wdata;
      n = 0;
      while (!tim_penable && n < 10) begin @(negedge sys_clk); n++; end
      repeat (2) @(negedge sys_clk);
      #3;
      sys_rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", {tim_psel, tim_penable, busy, m0_ack, m1_ack}, 5'b0);
      exp_q.delete();
      slv_q.delete();
      rd_pend = 1'b0;
      mdl_rdata[0] = '0;
      mdl_rdata[1] = '0;
      mdl_last = 1'b0;
      t0.k = 2;
      t0.id = 1'b0;
      push(t0);
      @(negedge sys_clk);
      chk("reset_rdata_cleared", {m0_rdata, m1_rdata}, 0);
      sys_rst_n = 1'b1;
      @(negedge sys_clk);
      chk("setup_after_reset", {tim_psel, tim_penable}, 2'b10);
      n = 0;
      while (m0_req && n < 20) begin
         @(negedge sys_clk);
         n++;
         if (m0_ack) m0_req = 1'b0;
      end
      if (m0_req) begin fail("reset_retry_no_ack"); m0_req = 1'b0; end

      // Randomised rounds.
      for (int r = 0; r < 40; r++) begin
         gap();
         mode = int'($urandom_range(1, 3));
         t0 = rnd_txn();
         t1 = rnd_txn();
         run_round(mode[0], mode[1], t0, t1);
      end

      repeat (3) @(negedge sys_clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      chk("slave_queue_drained", slv_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
